camera_pose_ctrl: RTL and testbench



---
 rtl/camera_pose_pkg.sv | 52 +++++
 rtl/axis_repeat.sv | 62 ++++++
 rtl/camera_pose_ctrl.sv | 109 ++++++++++
 tb/tb_camera_pose_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/camera_pose_pkg.sv
// Shared types, default parameters and saturating / modulo step helpers
// for the button-driven camera pose controller.
package camera_pose_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } axis_state_e;

  localparam int X_W_DEF          = 11;
  localparam int Y_W_DEF          = 11;
  localparam int ANG_W_DEF        = 9;
  localparam int X_INIT_DEF       = 300;
  localparam int Y_INIT_DEF       = 300;
  localparam int XY_STEP_DEF      = 1;
  localparam int ANG_STEP_DEF     = 5;
  localparam int ANG_MOD_DEF      = 360;
  localparam int REPEAT_DELAY_DEF = 16250000;
  localparam int REPEAT_RATE_DEF  = 3250000;
  localparam int CNT_W_DEF        = 24;

  // One step towards hi or lo, saturating at the bound (underflow included).
  function automatic logic [31:0] clamp_step(input logic [31:0] cur, input logic is_inc,
                                             input logic [31:0] step, input logic [31:0] lo,
                                             input logic [31:0] hi);
    logic [32:0] sum_v;
    logic [31:0] res_v;
    if (is_inc) begin
      sum_v = {1'b0, cur} + {1'b0, step};
      res_v = (sum_v > {1'b0, hi}) ? hi : sum_v[31:0];
    end else begin
      sum_v = {1'b0, lo} + {1'b0, step};
      res_v = ({1'b0, cur} < sum_v) ? lo : (cur - step);
    end
    return res_v;
  endfunction

  function automatic logic [31:0] wrap_step(input logic [31:0] cur, input logic is_inc,
                                            input logic [31:0] step, input logic [31:0] modv);
    logic [32:0] sum_v;
    logic [31:0] res_v;
    if (is_inc) begin
      sum_v = {1'b0, cur} + {1'b0, step};
      res_v = (sum_v >= {1'b0, modv}) ? (sum_v[31:0] - modv) : sum_v[31:0];
    end else begin
      res_v = (cur < step) ? (cur + modv - step) : (cur - step);
    end
    return res_v;
  endfunction

endpackage

// File: rtl/axis_repeat.sv
// Per-axis press/auto-repeat sequencer: turns an inc/dec button pair into
// single-cycle step pulses (first step on the press edge, then delay/rate).
module axis_repeat
  import camera_pose_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic hold_off,
  output logic step_inc,
  output logic step_dec
);

  axis_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_prev_dir;
  logic [1:0]       w_dir;
  logic             w_active;
  logic             w_new_press;
  logic             w_expire;
  logic             w_step;

  // w_dir = {dec-only, inc-only}; both pressed cancel to 2'b00
  assign w_dir       = {dec & ~inc, inc & ~dec};
  assign w_active    = (w_dir != 2'b00);
  assign w_new_press = w_active && (w_dir != r_prev_dir);
  assign w_expire    = w_active && (w_dir == r_prev_dir) && (r_state != IDLE) &&
                       (r_cnt == {CNT_W{1'b0}});
  assign w_step      = ~reset & ~hold_off & (w_new_press | w_expire);
  assign step_inc    = w_step & w_dir[0];
  assign step_dec    = w_step & w_dir[1];

  // Previous direction always tracks the buttons so held presses need a re-press after reset/home
  always_ff @(posedge clk) begin
    r_prev_dir <= w_dir;
    if (reset || hold_off) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (!w_active) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_new_press) begin
      r_state <= DELAY;
      r_cnt   <= CNT_W'(REPEAT_DELAY - 1);
    end else if (r_state == IDLE) begin
      r_state <= IDLE;
      r_cnt   <= r_cnt;
    end else if (r_cnt == {CNT_W{1'b0}}) begin
      r_state <= REPEAT;
      r_cnt   <= CNT_W'(REPEAT_RATE - 1);
    end else begin
      r_state <= r_state;
      r_cnt   <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/camera_pose_ctrl.sv
// Camera pose controller: three auto-repeat axes drive clamped x/y offsets
// and a modulo angle, with a home command and a pose-changed strobe.
module camera_pose_ctrl
  import camera_pose_pkg::*;
#(
  parameter int X_W          = X_W_DEF,
  parameter int Y_W          = Y_W_DEF,
  parameter int ANG_W        = ANG_W_DEF,
  parameter int X_INIT       = X_INIT_DEF,
  parameter int Y_INIT       = Y_INIT_DEF,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 1023,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 767,
  parameter int XY_STEP      = XY_STEP_DEF,
  parameter int ANG_STEP     = ANG_STEP_DEF,
  parameter int ANG_MOD      = ANG_MOD_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             rot_left,
  input  logic             rot_right,
  input  logic             home,
  output logic [X_W-1:0]   x_offset,
  output logic [Y_W-1:0]   y_offset,
  output logic [ANG_W-1:0] angle,
  output logic             moved
);

  logic [X_W-1:0]   r_x,   w_x_next;
  logic [Y_W-1:0]   r_y,   w_y_next;
  logic [ANG_W-1:0] r_ang, w_ang_next;
  logic             r_moved;
  logic             w_x_inc, w_x_dec, w_y_inc, w_y_dec, w_a_inc, w_a_dec;
  logic             w_home_change;

  axis_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_axis_x (
    .clk(clk), .reset(reset), .inc(right), .dec(left), .hold_off(home),
    .step_inc(w_x_inc), .step_dec(w_x_dec)
  );

  axis_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_axis_y (
    .clk(clk), .reset(reset), .inc(down), .dec(up), .hold_off(home),
    .step_inc(w_y_inc), .step_dec(w_y_dec)
  );

  axis_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_axis_a (
    .clk(clk), .reset(reset), .inc(rot_right), .dec(rot_left), .hold_off(home),
    .step_inc(w_a_inc), .step_dec(w_a_dec)
  );

  // Next pose from this cycle's step pulses
  always_comb begin
    w_x_next   = r_x;
    w_y_next   = r_y;
    w_ang_next = r_ang;
    if (w_x_inc || w_x_dec) begin
      w_x_next = X_W'(clamp_step(32'(r_x), w_x_inc, 32'(XY_STEP), 32'(X_MIN), 32'(X_MAX)));
    end else begin
      w_x_next = r_x;
    end
    if (w_y_inc || w_y_dec) begin
      w_y_next = Y_W'(clamp_step(32'(r_y), w_y_inc, 32'(XY_STEP), 32'(Y_MIN), 32'(Y_MAX)));
    end else begin
      w_y_next = r_y;
    end
    if (w_a_inc || w_a_dec) begin
      w_ang_next = ANG_W'(wrap_step(32'(r_ang), w_a_inc, 32'(ANG_STEP), 32'(ANG_MOD)));
    end else begin
      w_ang_next = r_ang;
    end
  end

  assign w_home_change = (r_x != X_W'(X_INIT)) || (r_y != Y_W'(Y_INIT)) ||
                         (r_ang != {ANG_W{1'b0}});

  // Pose registers; moved is high only in cycles where a value really changed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= X_W'(X_INIT);
      r_y     <= Y_W'(Y_INIT);
      r_ang   <= {ANG_W{1'b0}};
      r_moved <= 1'b0;
    end else if (home) begin
      r_x     <= X_W'(X_INIT);
      r_y     <= Y_W'(Y_INIT);
      r_ang   <= {ANG_W{1'b0}};
      r_moved <= w_home_change;
    end else begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_ang   <= w_ang_next;
      r_moved <= (w_x_next != r_x) || (w_y_next != r_y) || (w_ang_next != r_ang);
    end
  end

  assign x_offset = r_x;
  assign y_offset = r_y;
  assign angle    = r_ang;
  assign moved    = r_moved;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// Bench for camera_pose_ctrl: directed steps plus random button traffic,
// checked every cycle against a press-age based reference model.
module tb_camera_pose_ctrl;

  localparam int DLY = 4, RATE = 2;
  localparam int XI = 300, YI = 300, XMIN = 0, XMAX = 1023, YMIN = 0, YMAX = 767;
  localparam int STEP = 1, ASTEP = 5, AMOD = 360;

  logic clk = 1'b0, reset = 1'b1, home = 1'b0;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, rot_left = 1'b0, rot_right = 1'b0;
  logic left4 = 1'b0;
  logic [10:0] x_offset, y_offset, x4, y4;
  logic [8:0]  angle, a4;
  logic        moved, moved4;

  int n_cmp = 0, n_fail = 0;
  int m_x = XI, m_y = YI, m_a = 0;
  bit m_moved = 1'b0;
  int m_prev[3], m_age[3];
  bit m_armed[3];

  camera_pose_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) u_dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
    .rot_left(rot_left), .rot_right(rot_right), .home(home),
    .x_offset(x_offset), .y_offset(y_offset), .angle(angle), .moved(moved)
  );

  camera_pose_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .XY_STEP(4), .X_INIT(2)) u_dut4 (
    .clk(clk), .reset(reset), .left(left4), .right(1'b0), .up(1'b0), .down(1'b0),
    .rot_left(1'b0), .rot_right(1'b0), .home(1'b0),
    .x_offset(x4), .y_offset(y4), .angle(a4), .moved(moved4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dir_of(input logic inc, input logic dec);
    return (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
  endfunction

  // One clock: advance the reference model on the edge, compare 1 time unit later
  task automatic tick();
    int d[3];
    int s[3];
    int nx, ny, na;
    d[0] = dir_of(right, left);
    d[1] = dir_of(down, up);
    d[2] = dir_of(rot_right, rot_left);
    @(posedge clk);
    nx = m_x; ny = m_y; na = m_a;
    for (int i = 0; i < 3; i++) s[i] = 0;
    if (reset || home) begin
      for (int i = 0; i < 3; i++) begin
        m_prev[i] = d[i]; m_armed[i] = 1'b0; m_age[i] = 0;
      end
      nx = XI; ny = YI; na = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (d[i] != 0 && d[i] != m_prev[i]) begin
          m_armed[i] = 1'b1; m_age[i] = 0; s[i] = d[i];
        end else if (d[i] == 0) begin
          m_armed[i] = 1'b0;
        end else if (m_armed[i]) begin
          m_age[i]++;
          if (m_age[i] >= DLY && ((m_age[i] - DLY) % RATE) == 0) s[i] = d[i];
        end
        m_prev[i] = d[i];
      end
      if (s[0] > 0) nx = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
      if (s[0] < 0) nx = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
      if (s[1] > 0) ny = (m_y + STEP > YMAX) ? YMAX : m_y + STEP;
      if (s[1] < 0) ny = (m_y - STEP < YMIN) ? YMIN : m_y - STEP;
      if (s[2] > 0) na = (m_a + ASTEP) % AMOD;
      if (s[2] < 0) na = (m_a - ASTEP + AMOD) % AMOD;
    end
    m_moved = reset ? 1'b0 : ((nx != m_x) || (ny != m_y) || (na != m_a));
    m_x = nx; m_y = ny; m_a = na;
    #1;
    check("x", 32'(x_offset), m_x);
    check("y", 32'(y_offset), m_y);
    check("angle", 32'(angle), m_a);
    check("moved", 32'(moved), 32'(m_moved));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 0; m_age[i] = 0; m_armed[i] = 1'b0;
    end
    // right held through reset must not step afterwards
    right = 1'b1;
    ticks(2);
    check("reset_x", 32'(x_offset), 300);
    check("reset_moved", 32'(moved), 0);
    reset = 1'b0;
    ticks(5);
    check("held_thru_reset_x", 32'(x_offset), 300);
    right = 1'b0; tick();
    right = 1'b1; tick();
    check("repress_x", 32'(x_offset), 301);
    right = 1'b0; tick();

    // step of 4 from 2 clamps at 0
    left4 = 1'b1; tick();
    check("step4_x", 32'(x4), 0);
    check("step4_moved", 32'(moved4), 1);
    check("step4_y", 32'(y4), 300);
    check("step4_a", 32'(a4), 0);
    tick();
    check("step4_floor_moved", 32'(moved4), 0);
    left4 = 1'b0; tick();

    // single tap then 10-cycle hold
    left = 1'b1; tick();
    check("tap_moved", 32'(moved), 1);
    left = 1'b0; tick();
    check("tap_moved_drop", 32'(moved), 0);
    left = 1'b1; ticks(10);
    check("hold10_x", 32'(x_offset), 296);
    left = 1'b0; tick();

    // angle wrap both directions, then 72 taps full circle
    rot_left = 1'b1; tick();
    check("wrap_dec", 32'(angle), 355);
    rot_left = 1'b0; tick();
    rot_right = 1'b1; tick();
    check("wrap_inc", 32'(angle), 0);
    rot_right = 1'b0; tick();
    for (int i = 0; i < 72; i++) begin
      rot_right = 1'b1; tick();
      rot_right = 1'b0; tick();
    end
    check("full_circle", 32'(angle), 0);

    // drive x to the upper clamp, then a fresh press must not move it
    right = 1'b1; ticks(1600);
    right = 1'b0; tick();
    check("x_at_max", 32'(x_offset), 1023);
    right = 1'b1; tick();
    check("max_press_x", 32'(x_offset), 1023);
    check("max_press_moved", 32'(moved), 0);
    right = 1'b0; tick();

    // opposing buttons cancel; releasing one restarts from a fresh press
    left = 1'b1; right = 1'b1; ticks(5);
    check("cancel_x", 32'(x_offset), 1023);
    right = 1'b0; tick();
    check("release_right_x", 32'(x_offset), 1022);
    ticks(6);
    check("restart_sched_x", 32'(x_offset), 1020);
    left = 1'b0; tick();

    // home with up held, no further steps until up is re-pressed
    up = 1'b1; ticks(6);
    check("up_hold_y", 32'(y_offset), 298);
    home = 1'b1; tick();
    check("home_y", 32'(y_offset), 300);
    check("home_moved", 32'(moved), 1);
    home = 1'b0; ticks(5);
    check("home_no_step_y", 32'(y_offset), 300);
    up = 1'b0; tick();
    up = 1'b1; tick();
    check("home_repress_y", 32'(y_offset), 299);
    up = 1'b0; tick();

    // reset in the middle of auto-repeat
    rot_right = 1'b1; ticks(10);
    reset = 1'b1; tick();
    check("midrep_reset_a", 32'(angle), 0);
    check("midrep_reset_x", 32'(x_offset), 300);
    reset = 1'b0; rot_right = 1'b0; tick();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) left      = ~left;
      if ($urandom_range(0, 5) == 0) right     = ~right;
      if ($urandom_range(0, 5) == 0) up        = ~up;
      if ($urandom_range(0, 5) == 0) down      = ~down;
      if ($urandom_range(0, 5) == 0) rot_left  = ~rot_left;
      if ($urandom_range(0, 5) == 0) rot_right = ~rot_right;
      home  = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
